// File: rtl/opb_register_simulink2ppc_pkg.sv
// Shared register map for the Simulink-to-PPC software register: word offsets
// and STATUS/CONTROL bit positions, plus helpers that assemble readback words.
package opb_register_simulink2ppc_pkg;

    localparam logic [1:0] OFF_DATA    = 2'd0;
    localparam logic [1:0] OFF_STATUS  = 2'd1;
    localparam logic [1:0] OFF_CONTROL = 2'd2;
    localparam logic [1:0] OFF_RSVD    = 2'd3;

    localparam int STAT_NEW_BIT    = 0;
    localparam int STAT_OVR_BIT    = 1;
    localparam int STAT_CNT_LSB    = 16;
    localparam int STAT_CNT_W      = 16;

    localparam int CTRL_CLR_BIT    = 0;
    localparam int CTRL_FREEZE_BIT = 1;

    function automatic logic [31:0] status_word(input logic [STAT_CNT_W-1:0] cnt,
                                                input logic                  ovr,
                                                input logic                  nf);
        logic [31:0] w;
        w = '0;
        w[STAT_CNT_LSB +: STAT_CNT_W] = cnt;
        w[STAT_OVR_BIT]               = ovr;
        w[STAT_NEW_BIT]               = nf;
        return w;
    endfunction

    function automatic logic [31:0] control_word(input logic frz);
        logic [31:0] w;
        w = '0;
        w[CTRL_FREEZE_BIT] = frz;
        return w;
    endfunction

endpackage

// File: rtl/opb_slave_ack_ctrl.sv
// OPB address decode and single-beat acknowledge generation, shared by the
// software-register slaves. accept marks the cycle a transfer is taken.
module opb_slave_ack_ctrl #(
    parameter int                AWIDTH   = 32,
    parameter logic [AWIDTH-1:0] BASEADDR = '0,
    parameter logic [AWIDTH-1:0] HIGHADDR = 'hFF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [0:AWIDTH-1] abus,
    input  logic              select,
    output logic              xfer_ack,
    output logic              accept,
    output logic [1:0]        word_off
);

    logic [AWIDTH-1:0] addr;
    logic              hit;

    // Bus bit 0 is the MSB, so a plain assignment yields the numeric address.
    assign addr     = abus;
    assign hit      = select && (addr >= BASEADDR) && (addr <= HIGHADDR);
    assign accept   = hit && !xfer_ack;
    assign word_off = addr[3:2];

    // Ack stage: one cycle after accept; a held select re-arms every other cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xfer_ack <= 1'b0;
        end else begin
            xfer_ack <= accept;
        end
    end

endmodule

// File: rtl/opb_register_simulink2ppc.sv
// OPB slave exposing a fabric-produced 32-bit word to the PowerPC as a
// read-only register, with new-data/overrun tracking and capture counting.
module opb_register_simulink2ppc #(
    parameter logic [31:0] C_BASEADDR   = 32'h0000_0000,
    parameter logic [31:0] C_HIGHADDR   = 32'h0000_00FF,
    parameter int          C_OPB_AWIDTH = 32,
    parameter int          C_OPB_DWIDTH = 32,
    parameter string       C_FAMILY     = "virtex6"
) (
    input  logic                    OPB_Clk,
    input  logic                    OPB_Rst_n,
    input  logic [0:C_OPB_AWIDTH-1] OPB_ABus,
    input  logic [0:3]              OPB_BE,
    input  logic [0:C_OPB_DWIDTH-1] OPB_DBus,
    input  logic                    OPB_RNW,
    input  logic                    OPB_select,
    input  logic                    OPB_seqAddr,
    output logic [0:C_OPB_DWIDTH-1] Sl_DBus,
    output logic                    Sl_xferAck,
    output logic                    Sl_errAck,
    output logic                    Sl_retry,
    output logic                    Sl_toutSup,
    input  logic [31:0]             user_data_in,
    input  logic                    user_valid,
    output logic                    user_ack
);

    import opb_register_simulink2ppc_pkg::*;

    logic        accept;
    logic [1:0]  word_off;
    logic [31:0] wdata;
    logic [31:0] rd_val;

    logic [31:0]           data_reg;
    logic                  new_flag;
    logic                  overrun;
    logic                  freeze;
    logic [STAT_CNT_W-1:0] count;

    logic capture;
    logic rd_data;
    logic ctrl_wr;
    logic ctrl_clr;
    logic ctrl_frz;
    logic unused_bits;

    opb_slave_ack_ctrl #(
        .AWIDTH   (C_OPB_AWIDTH),
        .BASEADDR (C_BASEADDR),
        .HIGHADDR (C_HIGHADDR)
    ) u_ack_ctrl (
        .clk      (OPB_Clk),
        .rst_n    (OPB_Rst_n),
        .abus     (OPB_ABus),
        .select   (OPB_select),
        .xfer_ack (Sl_xferAck),
        .accept   (accept),
        .word_off (word_off)
    );

    assign Sl_errAck  = 1'b0;
    assign Sl_retry   = 1'b0;
    assign Sl_toutSup = 1'b0;

    // Renumber write data LSB-first so CONTROL bit positions read naturally.
    assign wdata = OPB_DBus;

    assign capture  = user_valid && !freeze;
    assign rd_data  = accept && OPB_RNW && (word_off == OFF_DATA);
    assign ctrl_wr  = accept && !OPB_RNW && (word_off == OFF_CONTROL) && OPB_BE[3];
    assign ctrl_clr = ctrl_wr && wdata[CTRL_CLR_BIT];
    assign ctrl_frz = ctrl_wr && wdata[CTRL_FREEZE_BIT];

    assign unused_bits = ^{OPB_seqAddr, OPB_BE[0:2], wdata[31:2]};

    always_comb begin
        rd_val = '0;
        case (word_off)
            OFF_DATA:    rd_val = data_reg;
            OFF_STATUS:  rd_val = status_word(count, overrun, new_flag);
            OFF_CONTROL: rd_val = control_word(freeze);
            OFF_RSVD:    rd_val = '0;
        endcase
    end

    // Accept stage: readback is latched here and driven only during the ack
    // cycle, keeping the OR-combined bus at zero otherwise.
    always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
        if (!OPB_Rst_n) begin
            Sl_DBus  <= '0;
            user_ack <= 1'b0;
            data_reg <= '0;
            new_flag <= 1'b0;
            overrun  <= 1'b0;
            count    <= '0;
            freeze   <= 1'b0;
        end else begin
            Sl_DBus  <= (accept && OPB_RNW) ? rd_val : '0;
            user_ack <= capture;

            if (capture) begin
                data_reg <= user_data_in;
            end

            // A capture always leaves fresh data pending, even against a read or clear.
            if (capture) begin
                new_flag <= 1'b1;
            end else if (rd_data || ctrl_clr) begin
                new_flag <= 1'b0;
            end

            // Overrun only when unread data is replaced without being consumed.
            if (ctrl_clr) begin
                overrun <= 1'b0;
            end else if (capture && new_flag && !rd_data) begin
                overrun <= 1'b1;
            end

            if (ctrl_clr) begin
                count <= capture ? STAT_CNT_W'(1) : '0;
            end else if (capture) begin
                count <= count + STAT_CNT_W'(1);
            end

            if (ctrl_frz) begin
                freeze <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_opb_register_simulink2ppc.sv
// Self-checking bench: directed register-map scenarios pinned with literal
// values, then randomized bus/user traffic compared to a transaction model.
module tb_opb_register_simulink2ppc;

    localparam logic [31:0] BASE = 32'h8000_0000;
    localparam logic [31:0] HIGH = 32'h8000_00FF;

    logic        clk = 1'b0;
    logic        OPB_Rst_n;
    logic [0:31] OPB_ABus;
    logic [0:3]  OPB_BE;
    logic [0:31] OPB_DBus;
    logic        OPB_RNW;
    logic        OPB_select;
    logic        OPB_seqAddr;
    logic [0:31] Sl_DBus;
    logic        Sl_xferAck;
    logic        Sl_errAck;
    logic        Sl_retry;
    logic        Sl_toutSup;
    logic [31:0] user_data_in;
    logic        user_valid;
    logic        user_ack;

    int n_cmp = 0;
    int n_bad = 0;

    opb_register_simulink2ppc #(
        .C_BASEADDR   (BASE),
        .C_HIGHADDR   (HIGH),
        .C_OPB_AWIDTH (32),
        .C_OPB_DWIDTH (32),
        .C_FAMILY     ("virtex6")
    ) dut (
        .OPB_Clk      (clk),
        .OPB_Rst_n    (OPB_Rst_n),
        .OPB_ABus     (OPB_ABus),
        .OPB_BE       (OPB_BE),
        .OPB_DBus     (OPB_DBus),
        .OPB_RNW      (OPB_RNW),
        .OPB_select   (OPB_select),
        .OPB_seqAddr  (OPB_seqAddr),
        .Sl_DBus      (Sl_DBus),
        .Sl_xferAck   (Sl_xferAck),
        .Sl_errAck    (Sl_errAck),
        .Sl_retry     (Sl_retry),
        .Sl_toutSup   (Sl_toutSup),
        .user_data_in (user_data_in),
        .user_valid   (user_valid),
        .user_ack     (user_ack)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit          m_ack, m_uack, m_nf, m_ovr, m_frz;
    bit   [31:0] m_dbus, m_data;
    int          m_cnt;

    bit          m_take, m_cap, m_rd_data, m_wr_ctl, m_clr, m_setfrz;
    int unsigned m_addr, m_off;
    bit   [31:0] m_rv;

    always_comb begin
        m_addr    = OPB_ABus;
        m_off     = (m_addr / 4) % 4;
        m_take    = OPB_select && (m_addr >= BASE) && (m_addr <= HIGH) && !m_ack;
        m_cap     = user_valid && !m_frz;
        m_rd_data = m_take && OPB_RNW && (m_off == 0);
        m_wr_ctl  = m_take && !OPB_RNW && (m_off == 2) && OPB_BE[3];
        m_clr     = m_wr_ctl && OPB_DBus[31];
        m_setfrz  = m_wr_ctl && OPB_DBus[30];
        case (m_off)
            0:       m_rv = m_data;
            1:       m_rv = m_cnt * 65536 + int'(m_ovr) * 2 + int'(m_nf);
            2:       m_rv = int'(m_frz) * 2;
            default: m_rv = 0;
        endcase
    end

    always @(posedge clk or negedge OPB_Rst_n) begin
        if (!OPB_Rst_n) begin
            m_ack  <= 0; m_uack <= 0; m_dbus <= 0; m_data <= 0;
            m_nf   <= 0; m_ovr  <= 0; m_frz  <= 0; m_cnt  <= 0;
        end else begin
            m_ack  <= m_take;
            m_dbus <= (m_take && OPB_RNW) ? m_rv : 32'd0;
            m_uack <= m_cap;
            if (m_cap) m_data <= user_data_in;
            m_nf   <= m_cap ? 1'b1 : ((m_rd_data || m_clr) ? 1'b0 : m_nf);
            m_ovr  <= m_clr ? 1'b0 : ((m_cap && m_nf && !m_rd_data) ? 1'b1 : m_ovr);
            m_cnt  <= ((m_clr ? 0 : m_cnt) + (m_cap ? 1 : 0)) % 65536;
            if (m_setfrz) m_frz <= 1'b1;
        end
    end

    always @(negedge clk) begin
        check("xferAck", {31'b0, Sl_xferAck}, {31'b0, m_ack});
        check("Sl_DBus", Sl_DBus, m_dbus);
        check("user_ack", {31'b0, user_ack}, {31'b0, m_uack});
        check("tie_offs", {29'b0, Sl_errAck, Sl_retry, Sl_toutSup}, 32'd0);
    end

    // ---------------- stimulus helpers (start and end at posedge+2) ----------------
    task automatic tick();
        @(posedge clk); #2;
    endtask

    task automatic bus_xfer(input logic [31:0] a, input logic rnw, input logic [3:0] be,
                            input logic [31:0] wd, output logic [31:0] rd);
        int lat;
        OPB_ABus = a; OPB_RNW = rnw; OPB_BE = be; OPB_DBus = wd; OPB_select = 1'b1;
        lat = 0;
        rd  = '0;
        do begin
            @(posedge clk); lat++;
            @(negedge clk);
        end while (!Sl_xferAck && lat < 8);
        check("ack_latency", lat, 1);
        rd = Sl_DBus;
        tick();
        OPB_select = 1'b0; OPB_RNW = 1'b0; OPB_BE = 4'b0000; OPB_DBus = '0;
    endtask

    task automatic reg_read(input logic [1:0] off, input string name, input logic [31:0] exp);
        logic [31:0] rd;
        bus_xfer(BASE + {28'b0, off, 2'b00}, 1'b1, 4'b1111, 32'd0, rd);
        check(name, rd, exp);
    endtask

    task automatic ctrl_write(input logic [31:0] wd);
        logic [31:0] rd;
        bus_xfer(BASE + 32'h8, 1'b0, 4'b0001, wd, rd);
    endtask

    task automatic capture(input logic [31:0] d, input logic exp_ack);
        user_data_in = d; user_valid = 1'b1;
        tick();
        user_valid = 1'b0;
        @(negedge clk);
        check("user_ack_pulse", {31'b0, user_ack}, {31'b0, exp_ack});
        @(negedge clk);
        check("user_ack_single", {31'b0, user_ack}, 32'd0);
        tick();
    endtask

    task automatic held_select(input logic [31:0] a, input int ack_odd);
        OPB_ABus = a; OPB_RNW = 1'b1; OPB_BE = 4'b1111; OPB_select = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk);
            @(negedge clk);
            check("held_ack", {31'b0, Sl_xferAck}, (ack_odd != 0 && (k % 2) == 1) ? 32'd1 : 32'd0);
            if (ack_odd == 0) check("held_miss_dbus", Sl_DBus, 32'd0);
        end
        OPB_select = 1'b0;
        tick();
    endtask

    initial begin
        #200us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic [31:0] addr;
        logic [31:0] d;
        int          r;

        OPB_Rst_n = 1'b0; OPB_ABus = '0; OPB_BE = '0; OPB_DBus = '0; OPB_RNW = 1'b0;
        OPB_select = 1'b0; OPB_seqAddr = 1'b0; user_data_in = '0; user_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ack", {31'b0, Sl_xferAck}, 32'd0);
        check("rst_dbus", Sl_DBus, 32'd0);
        check("rst_uack", {31'b0, user_ack}, 32'd0);
        tick();
        OPB_Rst_n = 1'b1;
        tick();

        reg_read(2'd1, "status_after_reset", 32'h0000_0000);
        reg_read(2'd0, "data_after_reset",   32'h0000_0000);

        capture(32'hDEAD_BEEF, 1'b1);
        reg_read(2'd1, "status_new",       32'h0001_0001);
        reg_read(2'd0, "data_deadbeef",    32'hDEAD_BEEF);
        reg_read(2'd1, "status_consumed",  32'h0001_0000);

        ctrl_write(32'h1);
        capture(32'h1, 1'b1);
        capture(32'h2, 1'b1);
        reg_read(2'd1, "status_overrun", 32'h0002_0003);
        reg_read(2'd0, "data_second",    32'h0000_0002);

        // Clear coinciding with a capture in the same edge.
        fork
            ctrl_write(32'h1);
            begin
                user_data_in = 32'h77; user_valid = 1'b1;
                tick();
                user_valid = 1'b0;
            end
        join
        reg_read(2'd1, "status_clear_vs_capture", 32'h0001_0001);
        ctrl_write(32'h1);
        reg_read(2'd1, "status_cleared", 32'h0000_0000);

        // Capture during the ack cycle of a DATA read.
        capture(32'h0000_A5A5, 1'b1);
        fork
            bus_xfer(BASE, 1'b1, 4'b1111, 32'd0, rd);
            begin
                @(posedge clk); #2;
                user_data_in = 32'h0000_1234; user_valid = 1'b1;
                tick();
                user_valid = 1'b0;
            end
        join
        check("data_read_old_value", rd, 32'h0000_A5A5);
        reg_read(2'd1, "status_read_vs_capture", 32'h0002_0001);
        reg_read(2'd0, "data_new_value",         32'h0000_1234);

        ctrl_write(32'h2);
        for (int i = 0; i < 3; i++) capture($urandom, 1'b0);
        reg_read(2'd1, "status_frozen",  32'h0002_0000);
        reg_read(2'd2, "control_freeze", 32'h0000_0002);
        reg_read(2'd0, "data_frozen",    32'h0000_1234);
        reg_read(2'd3, "reserved_zero",  32'h0000_0000);

        // Reset while a read is outstanding: no ack may follow.
        OPB_ABus = BASE; OPB_RNW = 1'b1; OPB_BE = 4'b1111; OPB_select = 1'b1;
        #1 OPB_Rst_n = 1'b0;
        @(negedge clk);
        check("rst_mid_ack", {31'b0, Sl_xferAck}, 32'd0);
        @(posedge clk); @(negedge clk);
        check("rst_mid_ack2", {31'b0, Sl_xferAck}, 32'd0);
        check("rst_mid_dbus", Sl_DBus, 32'd0);
        tick();
        OPB_select = 1'b0; OPB_Rst_n = 1'b1;
        tick();
        reg_read(2'd2, "control_after_rst", 32'h0000_0000);
        reg_read(2'd1, "status_after_rst",  32'h0000_0000);

        held_select(HIGH + 32'd1, 0);
        held_select(BASE - 32'd4, 0);
        held_select(BASE + 32'h4, 1);

        for (int i = 0; i < 800; i++) begin
            OPB_Rst_n = ($urandom_range(0, 149) != 0);
            r = $urandom_range(0, 9);
            if (r == 0)      addr = HIGH + 32'd1 + $urandom_range(0, 15);
            else if (r == 1) addr = BASE - 32'd1 - $urandom_range(0, 15);
            else             addr = BASE + $urandom_range(0, 255);
            OPB_ABus    = addr;
            OPB_select  = ($urandom_range(0, 2) != 0);
            OPB_RNW     = 1'($urandom_range(0, 1));
            OPB_BE      = 4'($urandom_range(0, 15));
            d = $urandom;
            if ($urandom_range(0, 7) != 0) d[1] = 1'b0;
            OPB_DBus    = d;
            OPB_seqAddr = 1'($urandom_range(0, 1));
            user_valid  = ($urandom_range(0, 2) == 0);
            user_data_in = $urandom;
            tick();
        end
        OPB_Rst_n = 1'b1; OPB_select = 1'b0; user_valid = 1'b0;
        repeat (3) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
